// File: rtl/icache_fill_ctrl_pkg.sv
// Shared definitions for the instruction-cache miss/fill controller:
// field widths, memory bus commands and the fill FSM state encoding.
package icache_fill_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int OFF_W  = 3;
    localparam int IDX_W  = 7;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int DATA_W = 64;
    localparam int MTAG_W = 4;
    localparam int BLK_W  = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } fill_state_e;

    // A block address is the byte address with the offset bits dropped.
    function automatic logic [IDX_W-1:0] blk_idx(input logic [BLK_W-1:0] blk);
        return blk[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] blk_tag(input logic [BLK_W-1:0] blk);
        return blk[BLK_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// Miss/fill controller for a 128x64 direct-mapped instruction cache: returns hits
// combinationally and services one outstanding miss at a time over the tagged memory bus.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,

    input  logic [ADDR_W-1:0] proc2Icache_addr,
    input  logic              proc2Icache_en,
    output logic [DATA_W-1:0] Icache_data_out,
    output logic              Icache_valid_out,

    output logic [IDX_W-1:0]  rd1_idx,
    output logic [TAG_W-1:0]  rd1_tag,
    input  logic [DATA_W-1:0] rd1_data,
    input  logic              rd1_valid,

    output logic              wr1_en,
    output logic [IDX_W-1:0]  wr1_idx,
    output logic [TAG_W-1:0]  wr1_tag,
    output logic [DATA_W-1:0] wr1_data,

    output logic [1:0]        proc2mem_command,
    output logic [ADDR_W-1:0] proc2mem_addr,
    input  logic [MTAG_W-1:0] mem2proc_response,
    input  logic [DATA_W-1:0] mem2proc_data,
    input  logic [MTAG_W-1:0] mem2proc_tag
);

    fill_state_e       r_state;
    logic [MTAG_W-1:0] r_saved_tag;
    logic [BLK_W-1:0]  r_miss_blk;
    logic [DATA_W-1:0] r_fill_data;
    logic              r_wr_en;
    bus_cmd_e          r_cmd;

    logic [BLK_W-1:0]  w_fetch_blk;
    logic              w_idle;
    logic              w_miss;
    logic              w_tag_match;
    logic              w_unused_offset;

    assign w_fetch_blk = proc2Icache_addr[ADDR_W-1:OFF_W];
    // The cache is block-granular, so the byte offset never takes part in lookup.
    assign w_unused_offset = ^proc2Icache_addr[OFF_W-1:0];

    assign w_idle      = (r_state == IDLE);
    assign w_miss      = w_idle && proc2Icache_en && !rd1_valid;
    // Tag 0 means "no data this cycle", so it can never complete a fill.
    assign w_tag_match = (mem2proc_tag != '0) && (mem2proc_tag == r_saved_tag);

    assign rd1_idx          = blk_idx(w_fetch_blk);
    assign rd1_tag          = blk_tag(w_fetch_blk);
    assign Icache_data_out  = rd1_data;
    // A hit is only reported from IDLE so fetch never races an in-flight fill.
    assign Icache_valid_out = w_idle && proc2Icache_en && rd1_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_saved_tag <= '0;
            r_miss_blk  <= '0;
            r_fill_data <= '0;
            r_wr_en     <= 1'b0;
            r_cmd       <= BUS_NONE;
        end else begin
            // NOTE: default-low here makes wr1_en a one-cycle pulse without an extra branch per state.
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_miss_blk <= w_fetch_blk;
                        r_cmd      <= BUS_LOAD;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    // A zero response is a bus refusal; the LOAD stays up and is retried.
                    if (mem2proc_response != '0) begin
                        r_saved_tag <= mem2proc_response;
                        r_cmd       <= BUS_NONE;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_tag_match) begin
                        r_fill_data <= mem2proc_data;
                        r_wr_en     <= 1'b1;
                        r_state     <= FILL;
                    end
                end
                FILL: begin
                    r_saved_tag <= '0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wr1_en           = r_wr_en;
    assign wr1_idx          = blk_idx(r_miss_blk);
    assign wr1_tag          = blk_tag(r_miss_blk);
    assign wr1_data         = r_fill_data;
    assign proc2mem_command = r_cmd;
    assign proc2mem_addr    = {r_miss_blk, {OFF_W{1'b0}}};

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: a cache-memory model beside the DUT, directed miss/fill
// scenarios, then random fetches checked against a line-level reference of cache contents.
module tb_icache_fill_ctrl;
    import icache_fill_ctrl_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] proc2Icache_addr;
    logic              proc2Icache_en;
    logic [DATA_W-1:0] Icache_data_out;
    logic              Icache_valid_out;
    logic [IDX_W-1:0]  rd1_idx;
    logic [TAG_W-1:0]  rd1_tag;
    logic [DATA_W-1:0] rd1_data;
    logic              rd1_valid;
    logic              wr1_en;
    logic [IDX_W-1:0]  wr1_idx;
    logic [TAG_W-1:0]  wr1_tag;
    logic [DATA_W-1:0] wr1_data;
    logic [1:0]        proc2mem_command;
    logic [ADDR_W-1:0] proc2mem_addr;
    logic [MTAG_W-1:0] mem2proc_response;
    logic [DATA_W-1:0] mem2proc_data;
    logic [MTAG_W-1:0] mem2proc_tag;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    icache_fill_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .proc2Icache_addr  (proc2Icache_addr),
        .proc2Icache_en    (proc2Icache_en),
        .Icache_data_out   (Icache_data_out),
        .Icache_valid_out  (Icache_valid_out),
        .rd1_idx           (rd1_idx),
        .rd1_tag           (rd1_tag),
        .rd1_data          (rd1_data),
        .rd1_valid         (rd1_valid),
        .wr1_en            (wr1_en),
        .wr1_idx           (wr1_idx),
        .wr1_tag           (wr1_tag),
        .wr1_data          (wr1_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    // Cache memory beside the DUT: written only through wr1, read combinationally.
    logic              cache_clear;
    logic              c_valid [0:127];
    logic [TAG_W-1:0]  c_tag   [0:127];
    logic [DATA_W-1:0] c_data  [0:127];

    always @(posedge clock) begin
        if (cache_clear) begin
            for (int i = 0; i < 128; i++) c_valid[i] <= 1'b0;
        end else if (wr1_en) begin
            c_valid[wr1_idx] <= 1'b1;
            c_tag[wr1_idx]   <= wr1_tag;
            c_data[wr1_idx]  <= wr1_data;
        end
    end

    assign rd1_valid = c_valid[rd1_idx] && (c_tag[rd1_idx] == rd1_tag);
    assign rd1_data  = c_data[rd1_idx];

    // Reference contents: which block each line should hold, from address arithmetic alone.
    logic [TAG_W-1:0]  m_tag  [int];
    logic [DATA_W-1:0] m_data [int];

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a >> 3) % 128);
    endfunction

    function automatic logic [TAG_W-1:0] ref_tag(input logic [31:0] a);
        return TAG_W'(a >> 10);
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return m_tag.exists(ref_idx(a)) && (m_tag[ref_idx(a)] == ref_tag(a));
    endfunction

    function automatic logic [MTAG_W-1:0] noise_tag(input int mode, input int k,
                                                    input logic [MTAG_W-1:0] mtag);
        logic [MTAG_W-1:0] t;
        if (mode == 1) return (k == 0) ? 4'd2 : ((k == 1) ? 4'd5 : 4'd0);
        if (mode == 2) begin
            do t = 4'($urandom_range(0, 15)); while (t == mtag);
            return t;
        end
        return 4'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one full miss from the current IDLE cycle; ends in the re-lookup cycle after FILL.
    task automatic run_miss(input logic [31:0] addr, input int n_rej, input int lat,
                            input logic [MTAG_W-1:0] mtag, input logic [63:0] data,
                            input int noise, input bit do_redir, input logic [31:0] redir);
        proc2Icache_en    = 1'b1;
        proc2Icache_addr  = addr;
        mem2proc_response = '0;
        mem2proc_tag      = '0;
        #1;
        check("miss_valid", 64'(Icache_valid_out), 64'(0));
        check("miss_idle_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        for (int k = 0; k <= n_rej; k++) begin
            tick();
            mem2proc_response = (k == n_rej) ? mtag : 4'd0;
            #1;
            check("req_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
            check("req_addr", 64'(proc2mem_addr), 64'({addr[31:3], 3'b000}));
            check("req_valid", 64'(Icache_valid_out), 64'(0));
        end
        for (int k = 0; k <= lat; k++) begin
            tick();
            mem2proc_response = '0;
            if (k == 0 && do_redir) proc2Icache_addr = redir;
            mem2proc_tag  = (k == lat) ? mtag : noise_tag(noise, k, mtag);
            mem2proc_data = (k == lat) ? data : {$urandom, $urandom};
            #1;
            check("wait_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
            check("wait_no_wr", 64'(wr1_en), 64'(0));
            check("wait_valid", 64'(Icache_valid_out), 64'(0));
        end
        tick();
        mem2proc_tag  = '0;
        mem2proc_data = {$urandom, $urandom};
        #1;
        check("fill_en", 64'(wr1_en), 64'(1));
        check("fill_idx", 64'(wr1_idx), 64'(ref_idx(addr)));
        check("fill_tag", 64'(wr1_tag), 64'(ref_tag(addr)));
        check("fill_data", wr1_data, data);
        check("fill_valid", 64'(Icache_valid_out), 64'(0));
        m_tag[ref_idx(addr)]  = ref_tag(addr);
        m_data[ref_idx(addr)] = data;
        tick();
        #1;
        check("post_fill_wr", 64'(wr1_en), 64'(0));
        check("post_fill_valid", 64'(Icache_valid_out), 64'(ref_hit(proc2Icache_addr)));
        if (ref_hit(proc2Icache_addr))
            check("post_fill_data", Icache_data_out, m_data[ref_idx(proc2Icache_addr)]);
    endtask

    // One fetch from an IDLE cycle: a hit must not touch the bus, a miss goes through run_miss.
    task automatic do_access(input logic [31:0] addr, input int n_rej, input int lat,
                             input logic [MTAG_W-1:0] mtag, input int noise);
        proc2Icache_en   = 1'b1;
        proc2Icache_addr = addr;
        #1;
        if (ref_hit(addr)) begin
            check("hit_valid", 64'(Icache_valid_out), 64'(1));
            check("hit_data", Icache_data_out, m_data[ref_idx(addr)]);
            tick();
            check("hit_no_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        end else begin
            run_miss(addr, n_rej, lat, mtag, {$urandom, $urandom}, noise, 1'b0, 32'h0);
            tick();
        end
    endtask

    initial begin
        reset             = 1'b0;
        cache_clear       = 1'b1;
        proc2Icache_en    = 1'b0;
        proc2Icache_addr  = '0;
        mem2proc_response = '0;
        mem2proc_data     = '0;
        mem2proc_tag      = '0;
        #1;
        check("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        check("rst_wr", 64'(wr1_en), 64'(0));
        check("rst_addr", 64'(proc2mem_addr), 64'(0));
        check("rst_valid", 64'(Icache_valid_out), 64'(0));
        tick();
        tick();
        reset       = 1'b1;
        cache_clear = 1'b0;
        tick();

        // Preload idx 5 / tag 1 by a fill, then a same-cycle hit with no bus traffic.
        run_miss(32'h0000_0428, 0, 1, 4'd1, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 32'h0);
        tick();
        do_access(32'h0000_0428, 0, 0, 4'd1, 0);

        // Cold miss: two refusals, accept tag 3, data five WAIT cycles later.
        tick();
        run_miss(32'h0000_1000, 2, 5, 4'd3, 64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0, 32'h0);

        // Four refusals then tag 7: LOAD held five cycles at the same address.
        tick();
        run_miss(32'h0000_0C08, 4, 1, 4'd7, 64'h1111_2222_3333_4444, 0, 1'b0, 32'h0);

        // Waiting on tag 7 while the bus returns tags 2 and 5 first.
        tick();
        run_miss(32'h0000_1410, 0, 2, 4'd7, 64'h5555_6666_7777_8888, 1, 1'b0, 32'h0);

        // Redirect during WAIT: original line fills, then the new address misses from IDLE.
        tick();
        run_miss(32'h0000_0818, 1, 2, 4'd4, 64'h9999_AAAA_BBBB_CCCC, 0, 1'b1, 32'h0000_2000);
        run_miss(32'h0000_2000, 0, 1, 4'd6, 64'hFEED_FACE_0BAD_F00D, 0, 1'b0, 32'h0);

        // Reset while waiting on tag 9: the late return must never be written.
        tick();
        proc2Icache_en   = 1'b1;
        proc2Icache_addr = 32'h0000_4018;
        #1;
        check("rstmiss_idle_valid", 64'(Icache_valid_out), 64'(0));
        tick();
        mem2proc_response = 4'd9;
        #1;
        check("rstmiss_req_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
        tick();
        mem2proc_response = '0;
        #1;
        check("rstmiss_wait_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        tick();
        reset          = 1'b0;
        proc2Icache_en = 1'b0;
        #1;
        check("rstmiss_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        check("rstmiss_wr", 64'(wr1_en), 64'(0));
        check("rstmiss_addr", 64'(proc2mem_addr), 64'(0));
        tick();
        reset = 1'b1;
        tick();
        mem2proc_tag  = 4'd9;
        mem2proc_data = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        check("late_tag_wr0", 64'(wr1_en), 64'(0));
        tick();
        mem2proc_tag = '0;
        #1;
        check("late_tag_wr1", 64'(wr1_en), 64'(0));
        check("late_tag_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        proc2Icache_en   = 1'b1;
        proc2Icache_addr = 32'h0000_0428;
        #1;
        check("after_rst_hit", 64'(Icache_valid_out), 64'(ref_hit(32'h0000_0428)));
        tick();

        // Random fetches over a small index/tag space so hits, conflicts and misses mix.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                proc2Icache_en   = 1'b0;
                proc2Icache_addr = $urandom;
                #1;
                check("idle_valid", 64'(Icache_valid_out), 64'(0));
                tick();
                check("idle_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
            end else begin
                do_access((32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 3) |
                          32'($urandom_range(0, 7)),
                          $urandom_range(0, 3), $urandom_range(0, 4),
                          4'($urandom_range(1, 15)), 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
